des_decrypt_rounds: RTL and testbench

//   Inverse of the shiftingcidi encryption round/key-shift step: performs the full
//   16-round DES decryption Feistel network on pre-IP halves, one round per clock.

---
 rtl/des_pkg.sv | 83 ++++++++
 rtl/des_f_func.sv | 21 ++
 rtl/des_decrypt_rounds.sv | 87 ++++++++
 tb/tb_des_decrypt_rounds.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES permutation tables, S-box ROMs and round helper functions
package des_pkg;

   // Tables use DES numbering: entry value 1 is the MSB of the source word.
   localparam int E_TAB [48] = '{
      32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
       8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
      16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
      24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

   localparam int P_TAB [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

   localparam int PC2_TAB [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

   // One nibble per entry, row-major (row*16 + col), entry 0 in the top nibble.
   localparam logic [255:0] SBOX [8] = '{
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
      256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

   // Right-rotation applied to C/D before decrypt round i.
   localparam logic [1:0] RSH [16] = '{
      2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
      2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};

   function automatic logic [47:0] e_expand(input logic [31:0] r);
      logic [47:0] o;
      for (int j = 0; j < 48; j++) o[47-j] = r[32-E_TAB[j]];
      return o;
   endfunction

   function automatic logic [31:0] p_perm(input logic [31:0] s);
      logic [31:0] o;
      for (int j = 0; j < 32; j++) o[31-j] = s[32-P_TAB[j]];
      return o;
   endfunction

   function automatic logic [47:0] pc2(input logic [27:0] c, input logic [27:0] d);
      logic [55:0] cd;
      logic [47:0] o;
      cd = {c, d};
      for (int j = 0; j < 48; j++) o[47-j] = cd[56-PC2_TAB[j]];
      return o;
   endfunction

   function automatic logic [3:0] sbox(input logic [2:0] idx, input logic [5:0] six);
      logic [5:0]   n;
      logic [255:0] sh;
      n  = {six[5], six[0], six[4:1]};
      sh = SBOX[idx] >> {6'd63 - n, 2'b00};
      return sh[3:0];
   endfunction

   function automatic logic [31:0] f_round(input logic [31:0] r32, input logic [47:0] k48);
      logic [47:0] x;
      logic [31:0] s;
      x = e_expand(r32) ^ k48;
      for (int g = 0; g < 8; g++) s[31-4*g -: 4] = sbox(3'(g), x[47-6*g -: 6]);
      return p_perm(s);
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] amt);
      logic [27:0] o;
      case (amt)
         2'd1:    o = {x[0], x[27:1]};
         2'd2:    o = {x[1:0], x[27:2]};
         default: o = x;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/des_f_func.sv
// rtl/des_f_func.sv - combinational DES f-function: E, key mix, S-boxes, P
module des_f_func
   import des_pkg::*;
(
   input  logic [31:0] r,
   input  logic [47:0] k,
   output logic [31:0] f
);

   logic [47:0] x;
   logic [31:0] s;

   assign x = e_expand(r) ^ k;

   for (genvar g = 0; g < 8; g++) begin : g_sbox
      assign s[31-4*g -: 4] = sbox(3'(g), x[47-6*g -: 6]);
   end

   assign f = p_perm(s);

endmodule

// File: rtl/des_decrypt_rounds.sv
// rtl/des_decrypt_rounds.sv - iterative 16-round DES decrypt Feistel core with ap_ctrl_hs handshake
module des_decrypt_rounds
   import des_pkg::*;
#(
   parameter int NUM_ROUNDS = 16
) (
   input  logic        ap_clk,
   input  logic        ap_rst_n,
   input  logic        ap_start,
   output logic        ap_done,
   output logic        ap_idle,
   output logic        ap_ready,
   input  logic [27:0] C,
   input  logic [27:0] D,
   input  logic [31:0] L,
   input  logic [31:0] R,
   output logic [63:0] ap_return
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]  state;
   logic [3:0]  rnd;
   logic [27:0] c_reg, d_reg;
   logic [31:0] l_reg, r_reg;
   logic [31:0] f_out;
   logic [47:0] subkey;
   logic [1:0]  rot_amt;
   logic        last_rnd;

   assign subkey   = pc2(c_reg, d_reg);
   assign last_rnd = (rnd == 4'(NUM_ROUNDS - 1));
   // The extra single step after the last round closes the 28-bit cycle back to C0/D0.
   assign rot_amt  = last_rnd ? 2'd1 : RSH[rnd + 4'd1];

   des_f_func u_f (
      .r (r_reg),
      .k (subkey),
      .f (f_out)
   );

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state     <= S_IDLE;
         rnd       <= 4'd0;
         c_reg     <= 28'd0;
         d_reg     <= 28'd0;
         l_reg     <= 32'd0;
         r_reg     <= 32'd0;
         ap_return <= 64'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (ap_start) begin
                  c_reg <= C;
                  d_reg <= D;
                  l_reg <= L;
                  r_reg <= R;
                  rnd   <= 4'd0;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               l_reg <= r_reg;
               r_reg <= l_reg ^ f_out;
               c_reg <= rotr28(c_reg, rot_amt);
               d_reg <= rotr28(d_reg, rot_amt);
               rnd   <= rnd + 4'd1;
               if (last_rnd) begin
                  ap_return <= {l_reg ^ f_out, r_reg};
                  rnd       <= 4'd0;
                  state     <= S_DONE;
               end
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign ap_idle  = (state == S_IDLE);
   assign ap_done  = (state == S_DONE);
   assign ap_ready = (state == S_DONE);

endmodule

// File: tb/tb_des_decrypt_rounds.sv
// tb/tb_des_decrypt_rounds.sv - self-checking bench for des_decrypt_rounds
module tb_des_decrypt_rounds;

   logic        ap_clk = 1'b0;
   logic        ap_rst_n;
   logic        ap_start;
   logic        ap_done, ap_idle, ap_ready;
   logic [27:0] c_in, d_in;
   logic [31:0] l_in, r_in;
   logic [63:0] ap_return;

   int total = 0;
   int bad   = 0;

   localparam logic [63:0] FIPS_PT  = 64'hCC00CCFFF0AAF0AA;
   localparam logic [63:0] FIPS_NPT = 64'h33FF33000F550F55;

   typedef struct {
      string       name;
      logic [27:0] c, d;
      logic [31:0] l, r;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs [2];

   always #5 ap_clk = ~ap_clk;

   des_decrypt_rounds #(.NUM_ROUNDS(16)) dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .ap_start  (ap_start),
      .ap_done   (ap_done),
      .ap_idle   (ap_idle),
      .ap_ready  (ap_ready),
      .C         (c_in),
      .D         (d_in),
      .L         (l_in),
      .R         (r_in),
      .ap_return (ap_return)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge in the following IDLE cycle.
   task automatic run_op(input logic [27:0] c, input logic [27:0] d,
                         input logic [31:0] l, input logic [31:0] r,
                         output logic [63:0] res, output int lat, output logic rdy);
      c_in = c; d_in = d; l_in = l; r_in = r;
      ap_start = 1'b1;
      @(negedge ap_clk);
      ap_start = 1'b0;
      lat = 1;
      while (!ap_done && lat < 40) begin
         @(negedge ap_clk);
         lat++;
      end
      res = ap_return;
      rdy = ap_ready;
      @(negedge ap_clk);
   endtask

   task automatic round_trip(input string name, input logic [27:0] c1, input logic [27:0] d1,
                             input logic [27:0] c2, input logic [27:0] d2,
                             input logic [31:0] l, input logic [31:0] r);
      logic [63:0] y, z;
      int          lat;
      logic        rdy;
      run_op(c1, d1, l, r, y, lat, rdy);
      run_op(c2, d2, y[63:32], y[31:0], z, lat, rdy);
      check(name, z, {l, r});
   endtask

   initial begin
      logic [63:0] res, res2;
      int          lat, dones, done_at, idles;
      int          done_cyc [3];
      logic        rdy;
      logic [27:0] rc, rd;
      logic [31:0] rl, rr;

      vecs[0] = '{"fips",  28'hF0CCAAF, 28'h556678F, 32'h0A4CD995, 32'h43423234, FIPS_PT};
      vecs[1] = '{"compl", 28'h0F33550, 28'hAA99870, 32'hF5B3266A, 32'hBCBDCDCB, FIPS_NPT};

      ap_rst_n = 1'b0;
      ap_start = 1'b0;
      c_in = '0; d_in = '0; l_in = '0; r_in = '0;
      repeat (3) @(negedge ap_clk);
      check("rst_idle",   64'(ap_idle),  64'd1);
      check("rst_done",   64'(ap_done),  64'd0);
      check("rst_ready",  64'(ap_ready), 64'd0);
      check("rst_return", ap_return,     64'd0);
      ap_rst_n = 1'b1;
      @(negedge ap_clk);

      for (int i = 0; i < 2; i++) begin
         run_op(vecs[i].c, vecs[i].d, vecs[i].l, vecs[i].r, res, lat, rdy);
         check({vecs[i].name, "_ret"},   res,      vecs[i].exp);
         check({vecs[i].name, "_lat"},   64'(lat), 64'd17);
         check({vecs[i].name, "_ready"}, 64'(rdy), 64'd1);
         check({vecs[i].name, "_idle"},  64'(ap_idle), 64'd1);
      end

      // ap_start held high for three back-to-back operations
      c_in = vecs[0].c; d_in = vecs[0].d; l_in = vecs[0].l; r_in = vecs[0].r;
      ap_start = 1'b1;
      dones = 0; idles = 0;
      for (int n = 1; n <= 80 && dones < 3; n++) begin
         @(negedge ap_clk);
         if (ap_idle) idles++;
         if (ap_done) begin
            done_cyc[dones] = n;
            dones++;
            check("b2b_ret", ap_return, FIPS_PT);
            if (dones == 3) ap_start = 1'b0;
         end
      end
      ap_start = 1'b0;
      check("b2b_count", 64'(dones), 64'd3);
      check("b2b_first", 64'(done_cyc[0]), 64'd17);
      check("b2b_gap1",  64'(done_cyc[1] - done_cyc[0]), 64'd18);
      check("b2b_gap2",  64'(done_cyc[2] - done_cyc[1]), 64'd18);
      check("b2b_idles", 64'(idles), 64'd2);
      repeat (2) @(negedge ap_clk);

      // previous result is the complement vector; it must survive a new start
      run_op(vecs[1].c, vecs[1].d, vecs[1].l, vecs[1].r, res, lat, rdy);
      c_in = vecs[0].c; d_in = vecs[0].d; l_in = vecs[0].l; r_in = vecs[0].r;
      ap_start = 1'b1;
      @(negedge ap_clk);
      ap_start = 1'b0;
      dones = 0; done_at = 0; res = '0;
      for (int n = 1; n <= 40; n++) begin
         if (n == 6) begin
            check("hold_ret", ap_return, FIPS_NPT);
            c_in = vecs[1].c; d_in = vecs[1].d; l_in = vecs[1].l; r_in = vecs[1].r;
            ap_start = 1'b1;
         end
         if (n == 7) ap_start = 1'b0;
         if (ap_done) begin
            dones++;
            done_at = n;
            res = ap_return;
         end
         @(negedge ap_clk);
      end
      check("midstart_dones", 64'(dones),   64'd1);
      check("midstart_cycle", 64'(done_at), 64'd17);
      check("midstart_ret",   res,          FIPS_PT);

      // reset asserted during round 8
      c_in = vecs[1].c; d_in = vecs[1].d; l_in = vecs[1].l; r_in = vecs[1].r;
      ap_start = 1'b1;
      @(negedge ap_clk);
      ap_start = 1'b0;
      repeat (8) @(negedge ap_clk);
      ap_rst_n = 1'b0;
      #1;
      check("arst_idle",   64'(ap_idle), 64'd1);
      check("arst_done",   64'(ap_done), 64'd0);
      check("arst_return", ap_return,    64'd0);
      repeat (2) @(negedge ap_clk);
      ap_rst_n = 1'b1;
      dones = 0;
      for (int n = 0; n < 25; n++) begin
         @(negedge ap_clk);
         if (ap_done) dones++;
      end
      check("arst_nodone", 64'(dones), 64'd0);
      run_op(vecs[0].c, vecs[0].d, vecs[0].l, vecs[0].r, res, lat, rdy);
      check("arst_recover", res, FIPS_PT);

      // constant subkeys make decryption an involution
      round_trip("weak0_a", 28'h0, 28'h0, 28'h0, 28'h0, 32'h01234567, 32'h89ABCDEF);
      round_trip("weak0_b", 28'h0, 28'h0, 28'h0, 28'h0, 32'hDEADBEEF, 32'h00000000);
      round_trip("weak1",   28'hFFFFFFF, 28'hFFFFFFF, 28'hFFFFFFF, 28'hFFFFFFF,
                 32'h13579BDF, 32'h2468ACE0);
      round_trip("weak01",  28'h0, 28'hFFFFFFF, 28'h0, 28'hFFFFFFF,
                 32'hA5A5A5A5, 32'h5A5A5A5A);
      // alternating C/D: decrypting with the complemented halves is encryption
      round_trip("semi_c",  28'h5555555, 28'h0, 28'hAAAAAAA, 28'h0,
                 32'h0F1E2D3C, 32'h4B5A6978);
      round_trip("semi_cd", 28'h5555555, 28'hAAAAAAA, 28'hAAAAAAA, 28'h5555555,
                 32'hCAFEF00D, 32'h8BADF00D);

      // complementation property on random keys and blocks
      for (int i = 0; i < 3; i++) begin
         rc = 28'($urandom); rd = 28'($urandom);
         rl = $urandom;      rr = $urandom;
         run_op(rc, rd, rl, rr, res, lat, rdy);
         run_op(~rc, ~rd, ~rl, ~rr, res2, lat, rdy);
         check("compl_rand", res2, ~res);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
